// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared constants and helpers for the traffic light display.
//               Active-low 7-segment codes {dp,g,f,e,d,c,b,a} with dp off,
//               one-hot light codes {r,y,g}, the converter state encoding, and
//               the per-road digit mapping (dash on overflow, blank leading 0).
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [2:0] RYG_RED = 3'b100;
  localparam logic [2:0] RYG_YEL = 3'b010;
  localparam logic [2:0] RYG_GRN = 3'b001;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Returns {tens_seg, ones_seg} for a {hund,tens,ones} BCD value.
  function automatic logic [15:0] road_segs(input logic [11:0] bcd);
    logic [15:0] segs;
    if (bcd[11:8] != 4'd0) begin
      segs = {SEG_DASH, SEG_DASH};
    end else if (bcd[7:4] == 4'd0) begin
      segs = {SEG_BLANK, seg_encode(bcd[3:0])};
    end else begin
      segs = {seg_encode(bcd[7:4]), seg_encode(bcd[3:0])};
    end
    return segs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : traffic_bin2bcd
// Description : 8-bit sequential double-dabble binary to BCD converter.
//               A conversion starts whenever the input differs from the last
//               value converted; the BCD output only changes in DONE, so it
//               never exposes an intermediate result.
// Ports       : clk, rst_n      clock, async active-low reset
//               i_bin  [7:0]    binary input
//               o_bcd  [11:0]   {hund,tens,ones}, registered
//               o_done          high for the cycle the result is written
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_bin2bcd
  import traffic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_bin,
  output logic [11:0] o_bcd,
  output logic        o_done
);

  conv_state_t r_state, w_state_nxt;
  logic [7:0]  r_last,  w_last_nxt;
  logic [19:0] r_shift, w_shift_nxt;
  logic [2:0]  r_cnt,   w_cnt_nxt;
  logic [11:0] r_bcd,   w_bcd_nxt;
  logic [19:0] w_adj;
  logic [19:0] w_shifted;

  // Add-3 on each BCD nibble >= 5, then shift the whole register left.
  always_comb begin
    w_adj = r_shift;
    if (w_adj[11:8]  >= 4'd5) w_adj[11:8]  = w_adj[11:8]  + 4'd3;
    if (w_adj[15:12] >= 4'd5) w_adj[15:12] = w_adj[15:12] + 4'd3;
    if (w_adj[19:16] >= 4'd5) w_adj[19:16] = w_adj[19:16] + 4'd3;
    w_shifted = {w_adj[18:0], 1'b0};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_bcd_nxt   = r_bcd;
    case (r_state)
      CONV_IDLE: begin
        if (i_bin != r_last) begin
          w_last_nxt  = i_bin;
          w_shift_nxt = {12'd0, i_bin};
          w_cnt_nxt   = 3'd0;
          w_state_nxt = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        w_shift_nxt = w_shifted;
        w_cnt_nxt   = r_cnt + 3'd1;
        if (r_cnt == 3'd7) w_state_nxt = CONV_DONE;
      end
      CONV_DONE: begin
        w_bcd_nxt   = r_shift[19:8];
        w_state_nxt = CONV_IDLE;
      end
      default: w_state_nxt = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CONV_IDLE;
      r_last  <= 8'd0;
      r_shift <= 20'd0;
      r_cnt   <= 3'd0;
      r_bcd   <= 12'd0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcd   <= w_bcd_nxt;
    end
  end

  assign o_bcd  = r_bcd;
  assign o_done = (r_state == CONV_DONE);

endmodule
`default_nettype wire

// File: rtl/traffic_seg_disp.sv
`default_nettype none
// ============================================================================
// Module      : traffic_seg_disp
// Description : Four-digit multiplexed common-anode 7-segment display for both
//               road countdowns. Digit order: primary tens, primary ones,
//               secondary tens, secondary ones. Optional yellow blinking is
//               enabled with macro TRAFFIC_DISP_BLINK_EN.
// Ports       : clk, rst_n            clock, async active-low reset
//               prim/seco_wait_time   8-bit countdowns
//               prim/seco_ryg_light   {r,y,g} one-hot light state
//               dig_sel [3:0]         active-low digit enable, bit0=prim tens
//               seg     [7:0]         active-low {dp,g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_seg_disp
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] prim_wait_time,
  input  logic [7:0] seco_wait_time,
  input  logic [2:0] prim_ryg_light,
  input  logic [2:0] seco_ryg_light,
  output logic [3:0] dig_sel,
  output logic [7:0] seg
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [11:0]       w_prim_bcd, w_seco_bcd;
  logic              w_prim_done, w_seco_done;
  logic [15:0]       w_prim_segs, w_seco_segs;
  logic              w_prim_blank, w_seco_blank;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_idx;
  logic              w_scan_wrap;
  logic [3:0]        r_dig_sel, w_dig_nxt;
  logic [7:0]        r_seg,     w_seg_nxt;

  traffic_bin2bcd u_prim_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_bin  (prim_wait_time),
    .o_bcd  (w_prim_bcd),
    .o_done (w_prim_done)
  );

  traffic_bin2bcd u_seco_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_bin  (seco_wait_time),
    .o_bcd  (w_seco_bcd),
    .o_done (w_seco_done)
  );

  wire w_unused_done = &{1'b0, w_prim_done, w_seco_done};

  assign w_prim_segs = road_segs(w_prim_bcd);
  assign w_seco_segs = road_segs(w_seco_bcd);

`ifdef TRAFFIC_DISP_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  assign w_prim_blank = r_blink_phase && (prim_ryg_light == RYG_YEL);
  assign w_seco_blank = r_blink_phase && (seco_ryg_light == RYG_YEL);
`else
  // Light state has no effect on the digits in this build.
  assign w_prim_blank = 1'b0;
  assign w_seco_blank = 1'b0;
  wire w_unused_ryg = &{1'b0, prim_ryg_light, seco_ryg_light};
`endif

  assign w_scan_wrap = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
    end else if (w_scan_wrap) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_comb begin
    w_dig_nxt = 4'b1111;
    w_seg_nxt = SEG_BLANK;
    case (r_idx)
      2'd0: begin
        w_dig_nxt = 4'b1110;
        w_seg_nxt = w_prim_blank ? SEG_BLANK : w_prim_segs[15:8];
      end
      2'd1: begin
        w_dig_nxt = 4'b1101;
        w_seg_nxt = w_prim_blank ? SEG_BLANK : w_prim_segs[7:0];
      end
      2'd2: begin
        w_dig_nxt = 4'b1011;
        w_seg_nxt = w_seco_blank ? SEG_BLANK : w_seco_segs[15:8];
      end
      default: begin
        w_dig_nxt = 4'b0111;
        w_seg_nxt = w_seco_blank ? SEG_BLANK : w_seco_segs[7:0];
      end
    endcase
  end

  // Enable and segments come from the same register stage, so they always
  // switch together and no digit ever shows its neighbour's pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig_sel <= 4'b1111;
      r_seg     <= SEG_BLANK;
    end else begin
      r_dig_sel <= w_dig_nxt;
      r_seg     <= w_seg_nxt;
    end
  end

  assign dig_sel = r_dig_sel;
  assign seg     = r_seg;

endmodule
`default_nettype wire
